instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage placed directly upstream of the 16-bit single-cycle datapath. Owns the program counter, reads each 16-bit instruction as two bytes from a byte-wide instruction memory over a req/ack handshake, and buffers fetched instructions in a small FIFO. Each instruction leaves the FIFO with its PC over a valid/ready interface. A taken branch (`redirect`) from the datapath flushes the FIFO and restarts fetch at the target.

## Interface
- `RESET_PC`, 16'd10, PC loaded on reset.
- `DEPTH`, 2, prefetch FIFO entries; must be a power of 2 and at least 2.

Ports:
- `Clock`  in  1  the single clock. All state changes on the rising edge.
- `Reset_n`  in  1  reset, asynchronous and active-low.
- `mem_req`  out  1  byte read request (registered).
- `mem_addr`  out  16  byte address (registered).
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  read byte.
- `instr`  out  16  instruction at the FIFO head.
- `instr_pc`  out  16  PC of `instr`.
- `instr_valid`  out  1  FIFO not empty.
- `instr_ready`  in  1  datapath accepts the head entry.
- `redirect`  in  1  branch taken; one-cycle pulse.
- `redirect_pc`  in  16  branch target.

## Operation
- **Byte order:** big-endian. The byte at `fetch_pc` goes to `instr[15:8]`. The byte at `fetch_pc+1` goes to `instr[7:0]`. `fetch_pc` is always even; bit 0 of `redirect_pc` is forced to 0.
- **Memory handshake:**
  - A transfer completes in any cycle where `mem_req` and `mem_ack` are both 1.
  - Once raised, `mem_req` and `mem_addr` hold until that transfer completes.
  - `mem_ack` is ignored while `mem_req` is 0.
- **States:**
  - `HI`: when idle, raise `mem_req` with `mem_addr`=`fetch_pc`, but only if `count < DEPTH`. On ack, store the byte in `hi_byte` and go to `LO` with `mem_addr`=`fetch_pc+1`; `mem_req` stays 1.
  - `LO`: on ack, push {`fetch_pc`, `hi_byte`, `mem_rdata`}. Then `fetch_pc += 2`, wrapping 16'hFFFE -> 16'h0000, and go to `HI`. `mem_req` stays 1 if the FIFO still has space after this cycle's push and pop; otherwise it drops to 0.
  - `DRAIN`: holds the outstanding request until ack, discards the byte, then goes to `HI`.
- **Space reservation:** a fetch begins only when a slot is free. No push can occur between `HI` and `LO`, so the push in `LO` never overflows.
- **FIFO:**
  - Output is first-word-fall-through from registers.
  - A pop occurs when `instr_valid` and `instr_ready` are both 1.
  - A push and a pop may happen in the same cycle; `count` is then unchanged.
- **Redirect:** `redirect` has priority over every other event in its cycle.
  - FIFO is flushed (`count` = 0).
  - `fetch_pc` <= {`redirect_pc[15:1]`, 0}.
  - If a request is outstanding and not acked this cycle, go to `DRAIN`; otherwise go to `HI`.
  - A byte acked in the redirect cycle is discarded, with no push.
  - A pop in the redirect cycle still counts as accepted by the datapath.
  - A redirect while in `DRAIN` updates `fetch_pc` and stays in `DRAIN`.

## Timing
- **Reset (async, immediate) values:** state `HI`, `fetch_pc` = `RESET_PC`, `count` = 0, `mem_req` = 0, `mem_addr` = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0. An outstanding memory transaction is abandoned.
- **Start-up:** `mem_req` rises on the first rising edge after `Reset_n` deasserts.
- **Zero-wait memory** (ack in every cycle `req` is high):
  - `instr_valid` rises 2 cycles after `mem_req` first rises.
  - Sustained throughput is 1 instruction per 2 cycles.
- **Wait states:** each wait cycle on either byte adds 1 cycle.
- **Flush timing:** `instr_valid` is 0 in the cycle after `redirect`. Without `DRAIN`, the first instruction at the target is valid 3 cycles after the `redirect` cycle with zero-wait memory.
- **Outputs:** `instr` and `instr_pc` are stable while `instr_valid` = 1 and `instr_ready` = 0.

## Test plan
- **Reset and first fetch:** release `Reset_n`; memory holds 0x12 at 10 and 0x34 at 11, zero-wait -> `mem_addr` 10 then 11. `instr_valid` rises 2 cycles after `req`, with `instr` = 16'h1234 and `instr_pc` = 10.
- **Backpressure:** hold `instr_ready` = 0 -> exactly `DEPTH` instructions (PC 10, 12) are buffered, then `mem_req` = 0. Raising `instr_ready` drains PC 10 then PC 12 in order, and fetch resumes at 14.
- **Redirect, clean:** pulse `redirect` with `redirect_pc` = 16'h0041 while a request is not in flight -> FIFO empty next cycle; next `mem_addr` = 16'h0040 and the next `instr_pc` = 16'h0040.
- **Redirect with in-flight request:** memory delays ack 3 cycles; assert `redirect` to 16'h0100 during the delay -> `mem_addr` holds until ack, the byte is discarded, and the next request is at 16'h0100. No instruction from the old stream appears.
- **Wrap-around:** redirect to 16'hFFFE -> the instruction at 16'hFFFE is emitted, then the next fetch is at 16'h0000.
- **Async reset mid-fetch:** assert `Reset_n` = 0 while `mem_req` = 1 in state `LO` -> all outputs are 0 immediately, without a clock edge. After release, fetch restarts at `RESET_PC` = 10.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC owner; fetches 16-bit big-endian instructions as byte pairs
//            into a small prefetch FIFO, with branch redirect and flush.
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd10,
  parameter int          DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_HI    = 2'd0;
  localparam logic [1:0] ST_LO    = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [15:0]   r_fetch_pc;
  logic [7:0]    r_hi_byte;
  logic          r_mem_req;
  logic [15:0]   r_mem_addr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [15:0]   r_pc_mem  [DEPTH];
  logic [15:0]   r_ins_mem [DEPTH];

  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_after;
  logic [15:0]   w_target;
  logic [15:0]   w_pc_inc;

  assign w_xfer        = r_mem_req & mem_ack;
  assign w_push        = ~redirect & (r_state == ST_LO) & w_xfer;
  assign w_pop         = instr_valid & instr_ready;
  assign w_count_after = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_target      = redirect_pc & 16'hFFFE;
  assign w_pc_inc      = r_fetch_pc + 16'd2;

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = r_ins_mem[r_rd_ptr];
  assign instr_pc    = r_pc_mem[r_rd_ptr];

  // Fetch sequencer. A redirect with nothing left in flight issues the target
  // request immediately so the first target instruction lands 3 cycles later.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_HI;
      r_fetch_pc <= RESET_PC;
      r_hi_byte  <= 8'h00;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 16'h0000;
    end else if (redirect) begin
      r_fetch_pc <= w_target;
      if (r_mem_req && !mem_ack) begin
        r_state <= ST_DRAIN;
      end else begin
        r_state    <= ST_HI;
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_target;
      end
    end else begin
      case (r_state)
        ST_HI: begin
          if (!r_mem_req) begin
            if (r_count < C_DEPTH) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_fetch_pc;
            end
          end else if (mem_ack) begin
            r_hi_byte  <= mem_rdata;
            r_state    <= ST_LO;
            r_mem_addr <= r_fetch_pc | 16'h0001;
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_fetch_pc <= w_pc_inc;
            r_state    <= ST_HI;
            r_mem_addr <= w_pc_inc;
            r_mem_req  <= (w_count_after < C_DEPTH);
          end
        end
        ST_DRAIN: begin
          if (w_xfer) begin
            r_state   <= ST_HI;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_HI;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO with register-based first-word-fall-through head.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= 16'h0000;
        r_ins_mem[i] <= 16'h0000;
      end
    end else if (redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
        r_ins_mem[r_wr_ptr] <= {r_hi_byte, mem_rdata};
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_after;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed self-checking bench for instruction_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  int wait_cnt = 0;

  instruction_fetch_unit #(.RESET_PC(16'd10), .DEPTH(2)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 Clock = ~Clock;

  // Memory image: 0x12/0x34 at 10/11, elsewhere a[7:0] ^ 0x5A ^ (a[15:8] << 1).
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'd10) return 8'h12;
    if (a == 16'd11) return 8'h34;
    return a[7:0] ^ 8'h5A ^ {a[14:8], 1'b0};
  endfunction

  always @(posedge Clock) begin
    if (!mem_req || mem_ack) wait_cnt = 0;
    else                     wait_cnt = wait_cnt + 1;
  end

  always @(negedge Clock) begin
    if (mem_req && wait_cnt >= wait_states) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_byte(mem_addr);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int ws);
    wait_states = ws;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    Reset_n     = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
  endtask

  task automatic test_first_fetch();
    do_reset(0);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd10) begin errors++; $display("FAIL ff_req_hi: got req=%b addr=%h expected req=1 addr=000a", mem_req, mem_addr); end
    tick();
    checks++; if (mem_addr !== 16'd11 || instr_valid !== 1'b0) begin errors++; $display("FAIL ff_req_lo: got addr=%h valid=%b expected addr=000b valid=0", mem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'd10) begin errors++; $display("FAIL ff_instr: got v=%b instr=%h pc=%h expected v=1 instr=1234 pc=000a", instr_valid, instr, instr_pc); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd12) begin errors++; $display("FAIL ff_next_req: got req=%b addr=%h expected req=1 addr=000c", mem_req, mem_addr); end
  endtask

  task automatic test_backpressure();
    do_reset(0);
    repeat (5) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b expected 0", mem_req); end
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got req=%b valid=%b expected req=0 valid=1", mem_req, instr_valid); end
    checks++; if (instr !== 16'h1234 || instr_pc !== 16'd10) begin errors++; $display("FAIL bp_stable: got instr=%h pc=%h expected 1234/000a", instr, instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr !== 16'h5657 || instr_pc !== 16'd12 || mem_req !== 1'b0) begin errors++; $display("FAIL bp_second: got instr=%h pc=%h req=%b expected 5657/000c req=0", instr, instr_pc, mem_req); end
    tick();
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'd14) begin errors++; $display("FAIL bp_resume: got v=%b req=%b addr=%h expected v=0 req=1 addr=000e", instr_valid, mem_req, mem_addr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd12 || instr !== 16'h5657) begin errors++; $display("FAIL b2b_head: got v=%b pc=%h instr=%h expected v=1 000c 5657", instr_valid, instr_pc, instr); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd14) begin errors++; $display("FAIL b2b_req: got req=%b addr=%h expected req=1 addr=000e", mem_req, mem_addr); end
    instr_ready = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0 || instr_pc !== 16'd12) begin errors++; $display("FAIL b2b_full: got req=%b pc=%h expected req=0 pc=000c", mem_req, instr_pc); end
  endtask

  task automatic test_throughput();
    do_reset(0);
    instr_ready = 1'b1;
    repeat (3) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd10) begin errors++; $display("FAIL tp_first: got v=%b pc=%h expected v=1 pc=000a", instr_valid, instr_pc); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL tp_gap: got v=%b expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd12 || instr !== 16'h5657) begin errors++; $display("FAIL tp_second: got v=%b pc=%h instr=%h expected v=1 000c 5657", instr_valid, instr_pc, instr); end
    do_reset(1);
    instr_ready = 1'b1;
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ws_early: got v=%b expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd10) begin errors++; $display("FAIL ws_arrive: got v=%b pc=%h expected v=1 pc=000a", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_clean();
    do_reset(0);
    repeat (5) tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rc_flush: got v=%b expected 0", instr_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL rc_target: got req=%b addr=%h expected req=1 addr=0040", mem_req, mem_addr); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0041) begin errors++; $display("FAIL rc_lo: got v=%b addr=%h expected v=0 addr=0041", instr_valid, mem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== 16'h1A1B) begin errors++; $display("FAIL rc_instr: got v=%b pc=%h instr=%h expected v=1 0040 1a1b", instr_valid, instr_pc, instr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    int n;
    do_reset(3);
    instr_ready = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd10 || instr_valid !== 1'b0) begin errors++; $display("FAIL rf_hold: got req=%b addr=%h v=%b expected req=1 addr=000a v=0", mem_req, mem_addr, instr_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd10) begin errors++; $display("FAIL rf_hold2: got req=%b addr=%h expected req=1 addr=000a", mem_req, mem_addr); end
    tick();
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rf_drained: got req=%b v=%b expected req=0 v=0", mem_req, instr_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL rf_newreq: got req=%b addr=%h expected req=1 addr=0100", mem_req, mem_addr); end
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rf_timeout: got v=%b after %0d cycles expected v=1", instr_valid, n); end
    checks++; if (instr_pc !== 16'h0100 || instr !== 16'h5859) begin errors++; $display("FAIL rf_instr: got pc=%h instr=%h expected 0100 5859", instr_pc, instr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(0);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFE) begin errors++; $display("FAIL wr_req: got req=%b addr=%h expected req=1 addr=fffe", mem_req, mem_addr); end
    tick();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || instr !== 16'h5A5B) begin errors++; $display("FAIL wr_instr: got v=%b pc=%h instr=%h expected v=1 fffe 5a5b", instr_valid, instr_pc, instr); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wr_next_addr: got %h expected 0000", mem_addr); end
    tick();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL wr_pc0: got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(0);
    repeat (4) tick();
    Reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin errors++; $display("FAIL ar_mem: got req=%b addr=%h expected 0/0000", mem_req, mem_addr); end
    checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000) begin errors++; $display("FAIL ar_fifo: got v=%b instr=%h pc=%h expected 0/0000/0000", instr_valid, instr, instr_pc); end
    #1;
    Reset_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'd10) begin errors++; $display("FAIL ar_restart: got req=%b addr=%h expected req=1 addr=000a", mem_req, mem_addr); end
    tick();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd10 || instr !== 16'h1234) begin errors++; $display("FAIL ar_instr: got v=%b pc=%h instr=%h expected v=1 000a 1234", instr_valid, instr_pc, instr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_back_to_back();
    test_throughput();
    test_redirect_clean();
    test_redirect_inflight();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
